// File: rtl/squat_cfg_pkg.sv
`default_nettype none
// ============================================================================
// Module      : squat_cfg_pkg
// Description : Shared types and constants for the CPU configuration bus and
//               the cell-forwarding configuration table.
// Revision    : 1.0 - initial release
// ============================================================================
package squat_cfg_pkg;

    localparam int NUM_TX = 4;
    localparam int VPI_W  = 12;

    localparam logic BUS_INTEL    = 1'b1;
    localparam logic BUS_MOTOROLA = 1'b0;

    // One forwarding entry: transmit port mask in the upper bits, VPI below.
    typedef struct packed {
        logic [NUM_TX-1:0] fwd;
        logic [VPI_W-1:0]  vpi;
    } CellCfgType;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_CAPTURE = 2'd1,
        ST_WAIT    = 2'd2,
        ST_ACK     = 2'd3
    } cfg_state_t;

    // Decodes a host access request from the active-low bus pins.
    // Intel with both strobes low is illegal and never counts as a request.
    function automatic logic bus_request(input logic mode,
                                         input logic sel_n,
                                         input logic rd_ds_n,
                                         input logic wr_rw);
        logic req;
        if (mode == BUS_INTEL) begin
            req = !sel_n && (rd_ds_n != wr_rw);
        end else begin
            req = !sel_n && !rd_ds_n;
        end
        return req;
    endfunction

endpackage
`default_nettype wire

// File: rtl/cfg_table_mem.sv
`default_nettype none
// ============================================================================
// Module      : cfg_table_mem
// Description : Cell-forwarding configuration table. One write port, an
//               asynchronous host read port and a registered lookup port
//               with read-before-write behaviour. Cleared by reset.
// Revision    : 1.0 - initial release
// ============================================================================
module cfg_table_mem
    import squat_cfg_pkg::*;
#(
    parameter int DEPTH = 256,
    parameter int AW    = 8
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          i_we,
    input  logic [AW-1:0] i_wr_addr,
    input  CellCfgType    i_wr_data,
    input  logic [AW-1:0] i_rd_addr,
    output CellCfgType    o_rd_data,
    input  logic [AW-1:0] i_lk_addr,
    output CellCfgType    o_lk_data
);

    CellCfgType r_mem [DEPTH];
    CellCfgType r_lk_data;

    // Table storage: full synchronous clear on reset, otherwise single write.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else if (i_we) begin
            r_mem[i_wr_addr] <= i_wr_data;
        end
    end

    // Lookup port: samples the pre-write contents, so a same-edge write shows next cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_lk_data <= '0;
        end else begin
            r_lk_data <= r_mem[i_lk_addr];
        end
    end

    assign o_rd_data = r_mem[i_rd_addr];
    assign o_lk_data = r_lk_data;

endmodule
`default_nettype wire

// File: rtl/cpu_cfg_slave.sv
`default_nettype none
// ============================================================================
// Module      : cpu_cfg_slave
// Description : CPU configuration bus responder (Intel and Motorola modes)
//               owning the cell-forwarding table, plus a read-only lookup
//               port for the receive-side forwarder.
// Revision    : 1.0 - initial release
// ============================================================================
module cpu_cfg_slave
    import squat_cfg_pkg::*;
#(
    parameter int unsigned ACK_DELAY   = 1,
    parameter int          TABLE_DEPTH = 256
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       BusMode,
    input  logic [7:0] Addr,
    input  logic       Sel,
    input  CellCfgType DataIn,
    input  logic       Rd_DS,
    input  logic       Wr_RW,
    output CellCfgType DataOut,
    output logic       Rdy_Dtack,
    input  logic [7:0] lk_addr,
    output CellCfgType lk_data
);

    localparam logic [2:0] c_WAIT_INIT = (ACK_DELAY > 0) ? 3'(ACK_DELAY - 1) : 3'd0;

    cfg_state_t  r_state;
    logic        r_mode;
    logic        r_wr;
    logic [7:0]  r_addr;
    CellCfgType  r_wdata;
    logic [2:0]  r_cnt;
    logic        r_req_d;
    logic        r_rdy;
    CellCfgType  r_dout;

    logic        w_req;
    logic        w_start;
    logic        w_hold;
    logic        w_we;
    CellCfgType  w_rd_data;

    // A new access starts only on a fresh request edge, so a strobe still
    // held when an access completes can never retrigger it.
    assign w_req   = bus_request(BusMode, Sel, Rd_DS, Wr_RW);
    assign w_start = w_req && !r_req_d;

    // Access stays alive while Sel and the strobe of the latched mode/direction are held.
    assign w_hold = !Sel && ((r_mode == BUS_INTEL && r_wr) ? !Wr_RW : !Rd_DS);

    // The write commits in CAPTURE regardless of a later abort.
    assign w_we = (r_state == ST_CAPTURE) && r_wr;

    // Request history for edge detection; starts busy so a strobe held through reset is ignored.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_req_d <= 1'b1;
        end else begin
            r_req_d <= w_req;
        end
    end

    // Access FSM with registered ready/dtack and read data.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
            r_mode  <= BUS_INTEL;
            r_wr    <= 1'b0;
            r_addr  <= '0;
            r_wdata <= '0;
            r_cnt   <= '0;
            r_rdy   <= 1'b1;
            r_dout  <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_start) begin
                        r_state <= ST_CAPTURE;
                        r_mode  <= BusMode;
                        r_wr    <= !Wr_RW;
                        r_addr  <= Addr;
                        r_wdata <= DataIn;
                    end
                end
                ST_CAPTURE: begin
                    if (!w_hold) begin
                        r_state <= ST_IDLE;
                    end else begin
                        if (!r_wr) begin
                            r_dout <= w_rd_data;
                        end
                        if (ACK_DELAY == 0) begin
                            r_state <= ST_ACK;
                            r_rdy   <= 1'b0;
                        end else begin
                            r_state <= ST_WAIT;
                            r_cnt   <= c_WAIT_INIT;
                        end
                    end
                end
                ST_WAIT: begin
                    if (!w_hold) begin
                        r_state <= ST_IDLE;
                        r_dout  <= '0;
                    end else if (r_cnt == 3'd0) begin
                        r_state <= ST_ACK;
                        r_rdy   <= 1'b0;
                    end else begin
                        r_cnt <= r_cnt - 3'd1;
                    end
                end
                ST_ACK: begin
                    if (!w_hold) begin
                        r_state <= ST_IDLE;
                        r_rdy   <= 1'b1;
                        r_dout  <= '0;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    cfg_table_mem #(
        .DEPTH (TABLE_DEPTH),
        .AW    (8)
    ) u_table (
        .clk       (clk),
        .rst       (rst),
        .i_we      (w_we),
        .i_wr_addr (r_addr),
        .i_wr_data (r_wdata),
        .i_rd_addr (r_addr),
        .o_rd_data (w_rd_data),
        .i_lk_addr (lk_addr),
        .o_lk_data (lk_data)
    );

    assign DataOut   = r_dout;
    assign Rdy_Dtack = r_rdy;

endmodule
`default_nettype wire
